// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and constants for the branch resolve unit.
package branch_resolve_unit_pkg;

  localparam int unsigned XLEN_DEFAULT      = 32;
  localparam int unsigned BHT_DEPTH_DEFAULT = 64;

  typedef enum logic [1:0] {
    BR_COND = 2'b00,
    BR_JAL  = 2'b01,
    BR_JALR = 2'b10,
    BR_RSVD = 2'b11
  } br_kind_e;

  typedef enum logic [2:0] {
    F3_BEQ   = 3'b000,
    F3_BNE   = 3'b001,
    F3_RSVD2 = 3'b010,
    F3_RSVD3 = 3'b011,
    F3_BLT   = 3'b100,
    F3_BGE   = 3'b101,
    F3_BLTU  = 3'b110,
    F3_BGEU  = 3'b111
  } br_funct3_e;

  // Weakly not-taken
  localparam logic [1:0] BHT_RESET = 2'b01;

  // Two-bit saturating counter step
  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    res = ctr;
    if (taken) begin
      if (ctr != 2'b11) res = ctr + 2'd1;
    end else begin
      if (ctr != 2'b00) res = ctr - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Request/result handshake bundle of the branch resolve unit.
interface branch_resolve_unit_if
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
);

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [XLEN-1:0] in_imm;
  logic [2:0]      in_funct3;
  logic [1:0]      in_kind;
  logic            in_pred_taken;
  logic [XLEN-1:0] in_pred_target;

  logic            out_valid;
  logic            out_ready;
  logic            out_taken;
  logic [XLEN-1:0] out_target;
  logic [XLEN-1:0] out_link;
  logic [XLEN-1:0] out_redirect_pc;
  logic            out_mispredict;
  logic            out_illegal;
  logic            out_misaligned;

  modport master (
    output in_valid, in_pc, in_rs1, in_rs2, in_imm, in_funct3, in_kind,
           in_pred_taken, in_pred_target, out_ready,
    input  in_ready, out_valid, out_taken, out_target, out_link,
           out_redirect_pc, out_mispredict, out_illegal, out_misaligned
  );

  modport slave (
    input  in_valid, in_pc, in_rs1, in_rs2, in_imm, in_funct3, in_kind,
           in_pred_taken, in_pred_target, out_ready,
    output in_ready, out_valid, out_taken, out_target, out_link,
           out_redirect_pc, out_mispredict, out_illegal, out_misaligned
  );

endinterface

// File: rtl/branch_resolve_unit_bht_counter_table.sv
// Array of 2-bit saturating counters: async read, sync update, sync reset.
module branch_resolve_unit_bht_counter_table
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned DEPTH = BHT_DEPTH_DEFAULT,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  logic [1:0] ctr [DEPTH];

  // Counter storage: reset to weakly not-taken, otherwise saturating train
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) ctr[i] <= BHT_RESET;
    end else if (upd_en) begin
      ctr[upd_idx] <= sat_update(ctr[upd_idx], upd_taken);
    end
  end

  // Read returns the pre-update value in an update cycle
  assign rd_ctr = ctr[rd_idx];

endmodule

// File: rtl/branch_resolve_unit.sv
// Registered, handshaked branch/jump resolution with a trained BHT.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter  int unsigned XLEN      = XLEN_DEFAULT,
  parameter  int unsigned BHT_DEPTH = BHT_DEPTH_DEFAULT,
  localparam int unsigned BHT_IDX_W = $clog2(BHT_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_resolve_unit_if.slave  bus,
  input  logic                  flush,
  input  logic [XLEN-1:0]       lookup_pc,
  output logic                  lookup_taken
);

  typedef struct packed {
    logic                 taken;
    logic [XLEN-1:0]      target;
    logic [XLEN-1:0]      link;
    logic [XLEN-1:0]      redirect;
    logic                 mispredict;
    logic                 illegal;
    logic                 misaligned;
    logic                 train;
    logic [BHT_IDX_W-1:0] idx;
  } res_t;

  res_t            nxt;
  res_t            res_q;
  logic            valid_q;
  br_kind_e        kind;
  br_funct3_e      f3;
  logic [XLEN-1:0] jalr_sum;
  logic            eq;
  logic            lt_s;
  logic            lt_u;
  logic            accept;
  logic            retire;
  logic            train_en;
  logic [1:0]      lookup_ctr;
  logic            unused_lookup_bits;

  assign eq   = bus.in_rs1 == bus.in_rs2;
  assign lt_s = $signed(bus.in_rs1) < $signed(bus.in_rs2);
  assign lt_u = bus.in_rs1 < bus.in_rs2;

  // Resolve direction, target and prediction check for the incoming request
  always_comb begin
    nxt        = '0;
    kind       = br_kind_e'(bus.in_kind);
    f3         = br_funct3_e'(bus.in_funct3);
    jalr_sum   = bus.in_rs1 + bus.in_imm;
    nxt.link   = bus.in_pc + XLEN'(4);
    nxt.target = bus.in_pc + bus.in_imm;
    case (kind)
      BR_COND: begin
        case (f3)
          F3_BEQ:  nxt.taken = eq;
          F3_BNE:  nxt.taken = !eq;
          F3_BLT:  nxt.taken = lt_s;
          F3_BGE:  nxt.taken = !lt_s;
          F3_BLTU: nxt.taken = lt_u;
          F3_BGEU: nxt.taken = !lt_u;
          default: nxt.illegal = 1'b1;
        endcase
      end
      BR_JAL:  nxt.taken = 1'b1;
      BR_JALR: begin
        nxt.taken  = 1'b1;
        nxt.target = jalr_sum & ~XLEN'(1);
      end
      default: nxt.illegal = 1'b1;
    endcase
    nxt.redirect   = nxt.taken ? nxt.target : nxt.link;
    nxt.mispredict = (nxt.taken != bus.in_pred_taken) ||
                     (nxt.taken && (nxt.target != bus.in_pred_target));
    nxt.misaligned = nxt.taken && (nxt.target[1:0] != 2'b00);
    nxt.train      = (kind == BR_COND) && !nxt.illegal;
    nxt.idx        = bus.in_pc[BHT_IDX_W+1:2];
  end

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign retire       = valid_q && bus.out_ready;
  assign train_en     = retire && res_q.train && !flush;

  // Result register; flush wins over accept, hold while stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      res_q   <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      res_q   <= nxt;
    end else if (retire) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_valid       = valid_q;
  assign bus.out_taken       = res_q.taken;
  assign bus.out_target      = res_q.target;
  assign bus.out_link        = res_q.link;
  assign bus.out_redirect_pc = res_q.redirect;
  assign bus.out_mispredict  = res_q.mispredict;
  assign bus.out_illegal     = res_q.illegal;
  assign bus.out_misaligned  = res_q.misaligned;

  branch_resolve_unit_bht_counter_table #(
    .DEPTH (BHT_DEPTH),
    .IDX_W (BHT_IDX_W)
  ) u_bht (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (lookup_pc[BHT_IDX_W+1:2]),
    .rd_ctr    (lookup_ctr),
    .upd_en    (train_en),
    .upd_idx   (res_q.idx),
    .upd_taken (res_q.taken)
  );

  assign lookup_taken = lookup_ctr[1];

  // Fetch PC bits outside the table index carry no prediction information
  assign unused_lookup_bits = ^{lookup_pc[XLEN-1:BHT_IDX_W+2], lookup_pc[1:0], lookup_ctr[0]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit with directed vectors.
module tb_branch_resolve_unit;
  import branch_resolve_unit_pkg::*;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic [XLEN-1:0] lookup_pc = 32'h40;
  logic            lookup_taken;

  branch_resolve_unit_if #(.XLEN(XLEN)) bus ();

  branch_resolve_unit #(.XLEN(XLEN), .BHT_DEPTH(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .flush        (flush),
    .lookup_pc    (lookup_pc),
    .lookup_taken (lookup_taken)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
    logic [31:0] link;
    logic [31:0] redirect;
    logic        mispredict;
    logic        illegal;
    logic        misaligned;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic exp_t mk(input logic t, input logic [31:0] tg, input logic [31:0] lk,
                              input logic [31:0] rd, input logic mp, input logic il, input logic ma);
    exp_t e;
    e.taken = t; e.target = tg; e.link = lk; e.redirect = rd;
    e.mispredict = mp; e.illegal = il; e.misaligned = ma;
    return e;
  endfunction

  // Monitor: every retiring result is checked against the queue head
  always @(negedge clk) begin : monitor
    exp_t got;
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      got.taken = bus.out_taken; got.target = bus.out_target; got.link = bus.out_link;
      got.redirect = bus.out_redirect_pc; got.mispredict = bus.out_mispredict;
      got.illegal = bus.out_illegal; got.misaligned = bus.out_misaligned;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL result_unexpected: got tgt=%h with empty scoreboard", got.target);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_err++;
          $display("FAIL result: got t=%b tgt=%h lnk=%h rd=%h mp=%b il=%b ma=%b, expected t=%b tgt=%h lnk=%h rd=%h mp=%b il=%b ma=%b",
                   got.taken, got.target, got.link, got.redirect, got.mispredict, got.illegal, got.misaligned,
                   e.taken, e.target, e.link, e.redirect, e.mispredict, e.illegal, e.misaligned);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic set_req(input logic [1:0] kind, input logic [2:0] f3, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                         input logic pt, input logic [31:0] ptgt);
    bus.in_valid = 1'b1; bus.in_kind = kind; bus.in_funct3 = f3; bus.in_pc = pc;
    bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_imm = imm;
    bus.in_pred_taken = pt; bus.in_pred_target = ptgt;
  endtask

  // Present a request until accepted; push its expected result on accept
  task automatic send(input logic [1:0] kind, input logic [2:0] f3, input logic [31:0] pc,
                      input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                      input logic pt, input logic [31:0] ptgt, input exp_t e);
    logic rdy;
    bit   done;
    done = 1'b0;
    set_req(kind, f3, pc, rs1, rs2, imm, pt, ptgt);
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      if (rdy) begin
        exp_q.push_back(e);
        done = 1'b1;
      end
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL accept_timeout: got no accept expected accept at pc=%h", pc);
    end
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] pcs [4];
    pcs[0] = 32'h40; pcs[1] = 32'h0; pcs[2] = 32'hFC; pcs[3] = 32'h100;
    bus.in_valid = 1'b0; bus.in_kind = 2'b00; bus.in_funct3 = 3'b000; bus.in_pc = '0;
    bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_imm = '0; bus.in_pred_taken = 1'b0;
    bus.in_pred_target = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_taken", 32'(bus.out_taken), 32'd0);
    chk("rst_out_target", bus.out_target, 32'd0);
    chk("rst_out_redirect", bus.out_redirect_pc, 32'd0);
    chk("rst_lookup", 32'(lookup_taken), 32'd0);
    @(posedge clk); #1;

    // Back-to-back directed vectors
    bus.out_ready = 1'b1;
    send(BR_COND, 3'b100, 32'h100, 32'hFFFFFFFF, 32'h1, 32'h20, 1'b0, 32'h0, mk(1, 32'h120, 32'h104, 32'h120, 1, 0, 0));
    send(BR_COND, 3'b110, 32'h100, 32'hFFFFFFFF, 32'h1, 32'h20, 1'b0, 32'h0, mk(0, 32'h120, 32'h104, 32'h104, 0, 0, 0));
    send(BR_JALR, 3'b000, 32'h200, 32'h1003, 32'h0, 32'h4, 1'b1, 32'h1006, mk(1, 32'h1006, 32'h204, 32'h1006, 0, 0, 1));
    send(BR_JAL, 3'b000, 32'h300, 32'h0, 32'h0, 32'hFFFFFFF0, 1'b1, 32'h2F0, mk(1, 32'h2F0, 32'h304, 32'h2F0, 0, 0, 0));
    send(BR_COND, 3'b101, 32'h400, 32'h5, 32'h5, 32'h8, 1'b1, 32'h40C, mk(1, 32'h408, 32'h404, 32'h408, 1, 0, 0));
    send(BR_COND, 3'b001, 32'h500, 32'h7, 32'h7, 32'h10, 1'b0, 32'h0, mk(0, 32'h510, 32'h504, 32'h504, 0, 0, 0));
    send(BR_COND, 3'b010, 32'h600, 32'h1, 32'h1, 32'h10, 1'b1, 32'h610, mk(0, 32'h610, 32'h604, 32'h604, 1, 1, 0));
    send(BR_RSVD, 3'b000, 32'h700, 32'h1, 32'h1, 32'h20, 1'b0, 32'h0, mk(0, 32'h720, 32'h704, 32'h704, 0, 1, 0));
    send(BR_JAL, 3'b000, 32'hFFFFFFFC, 32'h0, 32'h0, 32'h8, 1'b1, 32'h4, mk(1, 32'h4, 32'h0, 32'h4, 0, 0, 0));
    send(BR_COND, 3'b111, 32'h800, 32'h80000000, 32'h1, 32'hFFFFFFFE, 1'b1, 32'h7FE, mk(1, 32'h7FE, 32'h804, 32'h7FE, 0, 0, 1));
    send(BR_COND, 3'b100, 32'h900, 32'h80000000, 32'h7FFFFFFF, 32'h4, 1'b1, 32'h904, mk(1, 32'h904, 32'h904, 32'h904, 0, 0, 0));
    idle();
    cyc(3);
    chk("drain_vectors", 32'(exp_q.size()), 32'd0);

    // Backpressure: pending result held for three cycles
    bus.out_ready = 1'b0;
    send(BR_COND, 3'b100, 32'h100, 32'hFFFFFFFF, 32'h1, 32'h20, 1'b0, 32'h0, mk(1, 32'h120, 32'h104, 32'h120, 1, 0, 0));
    set_req(BR_COND, 3'b000, 32'hA00, 32'h3, 32'h3, 32'h40, 1'b1, 32'hA40);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_target_hold", bus.out_target, 32'h120);
      chk("bp_redirect_hold", bus.out_redirect_pc, 32'h120);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    send(BR_COND, 3'b000, 32'hA00, 32'h3, 32'h3, 32'h40, 1'b1, 32'hA40, mk(1, 32'hA40, 32'hA04, 32'hA40, 0, 0, 0));
    idle();
    @(negedge clk);
    chk("bp_next_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_next_target", bus.out_target, 32'hA40);
    @(posedge clk); #1;

    // BHT training at pc 0x40
    lookup_pc = 32'h40;
    send(BR_COND, 3'b000, 32'h40, 32'h1, 32'h1, 32'h10, 1'b0, 32'h0, mk(1, 32'h50, 32'h44, 32'h50, 1, 0, 0));
    idle();
    @(negedge clk);
    chk("bht_read_before_write", 32'(lookup_taken), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bht_first_taken", 32'(lookup_taken), 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++)
      send(BR_COND, 3'b000, 32'h40, 32'h1, 32'h1, 32'h10, 1'b0, 32'h0, mk(1, 32'h50, 32'h44, 32'h50, 1, 0, 0));
    idle();
    cyc(2);
    chk("bht_saturated", 32'(lookup_taken), 32'd1);
    send(BR_COND, 3'b000, 32'h40, 32'h1, 32'h2, 32'h10, 1'b0, 32'h0, mk(0, 32'h50, 32'h44, 32'h44, 0, 0, 0));
    idle();
    cyc(2);
    chk("bht_dec_to_10", 32'(lookup_taken), 32'd1);
    send(BR_COND, 3'b000, 32'h40, 32'h1, 32'h2, 32'h10, 1'b0, 32'h0, mk(0, 32'h50, 32'h44, 32'h44, 0, 0, 0));
    idle();
    cyc(2);
    chk("bht_dec_to_01", 32'(lookup_taken), 32'd0);
    send(BR_JAL, 3'b000, 32'h40, 32'h0, 32'h0, 32'h100, 1'b1, 32'h140, mk(1, 32'h140, 32'h44, 32'h140, 0, 0, 0));
    idle();
    cyc(2);
    chk("bht_jal_no_train", 32'(lookup_taken), 32'd0);

    // Flush with a pending result retiring and a new request presented
    bus.out_ready = 1'b0;
    send(BR_COND, 3'b000, 32'h40, 32'h1, 32'h1, 32'h10, 1'b0, 32'h0, mk(1, 32'h50, 32'h44, 32'h50, 1, 0, 0));
    set_req(BR_COND, 3'b000, 32'h40, 32'h1, 32'h1, 32'h10, 1'b0, 32'h0);
    flush = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    idle();
    @(negedge clk);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_no_train", 32'(lookup_taken), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("flush_discard", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;

    // Reset mid-operation
    send(BR_COND, 3'b000, 32'h40, 32'h1, 32'h1, 32'h10, 1'b0, 32'h0, mk(1, 32'h50, 32'h44, 32'h50, 1, 0, 0));
    idle();
    cyc(2);
    chk("pre_reset_lookup", 32'(lookup_taken), 32'd1);
    bus.out_ready = 1'b0;
    send(BR_COND, 3'b000, 32'h40, 32'h1, 32'h1, 32'h10, 1'b0, 32'h0, mk(1, 32'h50, 32'h44, 32'h50, 1, 0, 0));
    idle();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    @(negedge clk);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      lookup_pc = pcs[i];
      #1;
      chk("reset_lookup", 32'(lookup_taken), 32'd0);
    end
    @(posedge clk); #1;
    chk("final_drain", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Registered, handshaked branch/jump resolution stage for the RISC-V core; replaces the purely combinational branch compare.
- Takes operands, PC, immediate and the front-end prediction. One cycle later it returns the actual outcome, target, link address and a mispredict/redirect indication.
- Owns a parametrised table of 2-bit saturating counters (branch history table, BHT). The table is trained on retired conditional branches and read by the fetch stage through a combinational lookup port.

Parameters:
- XLEN, 32, datapath width (32 or 64).
- BHT_DEPTH, 64, number of 2-bit counters; power of two, minimum 2.
- BHT_IDX_W, $clog2(BHT_DEPTH), BHT index width (derived; do not override).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  stage can accept a request.
- in_pc  in  XLEN  PC of the branch/jump.
- in_rs1  in  XLEN  source operand 1.
- in_rs2  in  XLEN  source operand 2.
- in_imm  in  XLEN  sign-extended immediate.
- in_funct3  in  3  compare type: BEQ=000, BNE=001, BLT=100, BGE=101, BLTU=110, BGEU=111.
- in_kind  in  2  BR_COND=00, BR_JAL=01, BR_JALR=10, BR_RSVD=11.
- in_pred_taken  in  1  front-end predicted direction.
- in_pred_target  in  XLEN  front-end predicted target.
- flush  in  1  kill the in-flight and the incoming request.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_taken  out  1  actual direction.
- out_target  out  XLEN  actual taken target.
- out_link  out  XLEN  in_pc + 4.
- out_redirect_pc  out  XLEN  out_target if taken, else out_link.
- out_mispredict  out  1  prediction was wrong.
- out_illegal  out  1  reserved kind or funct3 (010/011).
- out_misaligned  out  1  taken with target[1:0] != 00.
- lookup_pc  in  XLEN  fetch PC to predict.
- lookup_taken  out  1  MSB of the counter at lookup_pc[BHT_IDX_W+1:2].

Behaviour:
- Reset, when rst_n=0 at a clk edge:
  - out_valid=0.
  - All result outputs = 0.
  - Every BHT counter = 2'b01 (weakly not-taken).
  - in_ready=1 the cycle after reset.
- Handshakes:
  - in_ready = !out_valid || out_ready.
  - Accept occurs when in_valid && in_ready. Retire occurs when out_valid && out_ready.
- Latency and throughput: exactly 1 cycle. Back-to-back accepts sustain one result per cycle while out_ready=1.
- Output hold: while out_valid && !out_ready, all outputs are held stable and no new request is accepted.
- Direction:
  - BEQ/BNE use full-width equality.
  - BLT/BGE use $signed over all XLEN bits.
  - BLTU/BGEU use unsigned compare.
  - JAL and JALR are always taken.
  - BR_RSVD, or funct3 010/011 with BR_COND: taken=0, out_illegal=1.
- Targets:
  - COND and JAL: pc + imm.
  - JALR: (rs1 + imm) with bit0 cleared.
  - All arithmetic is modulo 2^XLEN; wrap-around is silent.
- out_mispredict = (taken != pred_taken) || (taken && target != pred_target).
- out_misaligned is asserted only when taken. The redirect PC is still reported.
- BHT index = pc[BHT_IDX_W+1:2] of the retiring branch.
- BHT training:
  - On retire of BR_COND with !out_illegal and !flush, increment the counter (saturating at 11) if taken, else decrement (saturating at 00).
  - JAL and JALR never train.
- Lookup is combinational read-before-write: a lookup on the same index as the same-cycle update returns the old value.
- Flush, on a clk edge with flush=1:
  - out_valid <= 0.
  - Any request accepted in that cycle is discarded.
  - A result retiring in that cycle does not train the BHT.
  - Flush overrides in_valid.
- Reset mid-operation discards the in-flight result and reinitialises all counters.

Decomposition:
- RISCV.h holds XLEN, the BR_COND/BR_JAL/BR_JALR/BR_RSVD kind codes, the funct3 compare codes and the BHT reset value.
- Natural sub-module: bht_counter_table, a parametrised array of 2-bit saturating counters with one async read port, one sync update port and synchronous reset.

Test Plan:
- BLT signed compare: rs1=0xFFFFFFFF, rs2=0x00000001, pc=0x100, imm=0x20, pred_taken=0. Expect one cycle later: taken=1, target=0x120, redirect_pc=0x120, mispredict=1.
- BLTU unsigned compare: same operands. Expect taken=0, redirect_pc=0x104. With pred_taken=0, expect mispredict=0.
- JALR: rs1=0x1003, imm=0x4, pred_target=0x1006. Expect target=0x1006, link=pc+4, mispredict=0, misaligned=1.
- Backpressure: hold out_ready=0 for 3 cycles with a result pending. Expect in_ready=0 and outputs stable throughout. Raise out_ready; expect a next request presented on that cycle to be accepted and its result to appear the following cycle.
- BHT saturation: retire 4 taken BEQ at pc=0x40. Expect lookup_taken(0x40) to change 0→1 after the first retire and the counter to saturate at 11. A same-cycle lookup during an update returns the old value. Then 1 not-taken retire → counter 10, lookup still 1.
- Flush: flush=1 together with in_valid=1 while a result is pending. Expect out_valid=0 next cycle and no BHT change. Then rst_n=0 for 1 cycle: all lookups return 0 and out_valid=0.
